c_st_rx_buffer: RTL and testbench
=================================

Name: c_st_rx_buffer

Overview:
- Receiving end of the cSt ready/valid channel in the hierIncludeC subsystem.
- Accepts cSt beats from the upstream cSt transmitter into a small pointer-based FIFO and re-presents them to the local consumer on a second ready/valid port.
- Decouples producer and consumer timing, supports a synchronous flush, and optionally keeps receive statistics.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cSt_vld  in  1  upstream beat valid
- cSt_data  in  10  upstream beat (cSt, field cAnother of type cSizeT)
- cSt_rdy  out  1  upstream ready
- out_vld  out  1  downstream beat valid
- out_data  out  10  downstream beat (cSt)
- out_rdy  in  1  downstream ready
- flush  in  1  discard all buffered beats
- occupancy  out  $clog2(DEPTH)+1  entries currently held
- rx_count  out  CNT_W  beats accepted (C_ST_RX_STATS_EN only)
- rx_sum  out  CNT_W  saturating sum of accepted cAnother (C_ST_RX_STATS_EN only)

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values: cSt_rdy=0 during rst, then 1 from the first cycle after rst falls; out_vld=0; out_data=0; occupancy=0; rx_count=0; rx_sum=0.
- Push occurs when cSt_vld && cSt_rdy at a rising edge. Pop occurs when out_vld && out_rdy at a rising edge.
- cSt_rdy is a registered function of occupancy: cSt_rdy = (occupancy != DEPTH) && !flush.
  - No combinational path from out_rdy to cSt_rdy.
  - When full, a pop in the same cycle does not enable a push; push becomes possible the cycle after the pop.
- out_vld = (occupancy != 0). out_data is the entry at the read pointer and is stable while out_vld && !out_rdy.
- Latency: a beat pushed at edge N appears on out_vld/out_data after edge N (cycle N+1); minimum 1-cycle cut-through.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- Occupancy update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (possible only when 0 < occupancy < DEPTH)
- Empty: no pop possible, since out_vld is 0.
- Full: no push possible, since cSt_rdy is 0.
- flush takes priority over push and pop:
  - At the flush edge, pointers and occupancy clear to 0.
  - A coincident push is dropped and is not counted in the statistics.
  - A coincident pop is void.
  - out_vld is 0 from the next cycle.
  - Multi-cycle flush holds the buffer empty with cSt_rdy=0.
- rst asserted mid-transfer discards all contents and counters; there is no partial-beat state.
- Stored data is unmodified 10-bit cSt; no arithmetic on the data path.

Optional Feature:
- Macro: C_ST_RX_STATS_EN.
- Defined:
  - rx_count increments by 1 per accepted push and wraps at 2^CNT_W.
  - rx_sum adds the zero-extended cAnother per push and saturates at 2^CNT_W-1.
  - Neither counter is cleared by flush; only rst clears them.
- Undefined: rx_count and rx_sum ports are absent and no counter logic is generated.

Decomposition:
- Shared hierIncludeC package holds:
  - cSt and cSizeT (C_ANOTHER_SIZE=10 from the include package)
  - C_ST_RX_DEPTH=4
  - C_ST_RX_CNT_W=16
- One natural sub-module: c_st_fifo_mem, the DEPTH x cSt register array with write port (wr_en, wr_ptr, wr_data) and asynchronous read (rd_ptr -> rd_data).
- Pointer, occupancy and stats logic stay in c_st_rx_buffer.

Test Plan:
1. Reset release, then push 0x005, 0x3FF, 0x123 with out_rdy=1 -> out_data sequence 0x005, 0x3FF, 0x123; each beat appears 1 cycle after its push; occupancy peaks at 1.
2. out_rdy=0, push 5 beats -> first 4 accepted; cSt_rdy=0 after the 4th; occupancy=4. Then assert out_rdy for 1 cycle -> 1 pop; cSt_rdy=1 next cycle; the 5th beat is accepted one cycle later.
3. Occupancy=2, simultaneous push and pop for 6 cycles -> occupancy stays 2, pointers wrap, FIFO order preserved.
4. Occupancy=3 with flush and cSt_vld both high in one cycle -> next cycle occupancy=0, out_vld=0, cSt_rdy=0; the pushed beat never appears downstream.
5. With C_ST_RX_STATS_EN, push 70 beats of 0x3FF (1023) -> rx_count=70, rx_sum=65535 (saturated). After flush -> counters unchanged; after rst -> counters 0.
6. rst asserted with occupancy=3 and out_vld=1 -> next cycle out_vld=0, occupancy=0, cSt_rdy=0; cSt_rdy=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/c_st_rx_buffer_pkg.sv
// Shared cSt types and receive-buffer defaults for the hierIncludeC subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: cSizeT / cSt beat types, buffer depth and stats counter width.
package c_st_rx_buffer_pkg;

    localparam int C_ANOTHER_SIZE = 10;

    typedef logic [C_ANOTHER_SIZE-1:0] cSizeT;

    typedef struct packed {
        cSizeT cAnother;
    } cSt;

    localparam int C_ST_W        = $bits(cSt);
    localparam int C_ST_RX_DEPTH = 4;
    localparam int C_ST_RX_CNT_W = 16;

endpackage

// File: rtl/c_st_fifo_mem.sv
// DEPTH x cSt register array backing the cSt receive FIFO.
// Latency: write lands at the clock edge; read is combinational from rd_ptr.
// Backpressure: none; the owner decides when wr_en may fire.
//
// Ports: clk; wr_en/wr_ptr/wr_data write port; rd_ptr -> rd_data async read.
module c_st_fifo_mem
    import c_st_rx_buffer_pkg::*;
#(
    parameter int DEPTH = C_ST_RX_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [C_ST_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [C_ST_W-1:0] rd_data
);

    // Storage only; contents are meaningless until written, the owner's
    // occupancy tracking guarantees unwritten entries are never presented.
    cSt memArr [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            memArr[wr_ptr] <= cSt'(wr_data);
        end
    end

    assign rd_data = memArr[rd_ptr];

endmodule

// File: rtl/c_st_rx_buffer.sv
// Receive buffer for the cSt ready/valid channel: small pointer FIFO between producer and consumer.
// Latency: 1 cycle from accepted push to out_vld/out_data (cut-through when empty).
// Backpressure: cSt_rdy is registered from occupancy and flush; no combinational out_rdy->cSt_rdy path.
//
// Ports: clk, rst (sync, active-high); cSt_vld/cSt_data/cSt_rdy upstream; out_vld/out_data/out_rdy
// downstream; flush discards contents; occupancy = entries held; rx_count/rx_sum only when
// C_ST_RX_STATS_EN is defined (beats accepted, saturating sum of cAnother).
module c_st_rx_buffer
    import c_st_rx_buffer_pkg::*;
#(
    parameter int DEPTH = C_ST_RX_DEPTH
`ifdef C_ST_RX_STATS_EN
    ,
    parameter int CNT_W = C_ST_RX_CNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cSt_vld,
    input  logic [C_ST_W-1:0]        cSt_data,
    output logic                     cSt_rdy,
    output logic                     out_vld,
    output logic [C_ST_W-1:0]        out_data,
    input  logic                     out_rdy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef C_ST_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]         rx_count,
    output logic [CNT_W-1:0]         rx_sum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [OCC_W-1:0]  occReg;
    logic [OCC_W-1:0]  occNext;
    logic              rdyReg;
    logic              pushEn;
    logic              popEn;
    logic              wrEn;
    logic [C_ST_W-1:0] rdData;

    assign pushEn = cSt_vld && rdyReg;
    assign popEn  = out_vld && out_rdy;
    // A push coinciding with flush is dropped, so it never reaches storage.
    assign wrEn   = pushEn && !flush && !rst;

    always_comb begin
        occNext = occReg;
        if (flush) begin
            occNext = '0;
        end else begin
            case ({pushEn, popEn})
                2'b10:   occNext = occReg + OCC_W'(1);
                2'b01:   occNext = occReg - OCC_W'(1);
                default: occNext = occReg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            occReg <= '0;
            rdyReg <= 1'b0;
        end else begin
            occReg <= occNext;
            // Ready looks at next occupancy only, so a pop while full opens
            // the upstream port one cycle later rather than combinationally.
            rdyReg <= (occNext != FULL_OCC) && !flush;
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                // Pointers are exactly log2(DEPTH) bits and wrap naturally.
                if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
                if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    c_st_fifo_mem #(
        .DEPTH (DEPTH)
    ) uMem (
        .clk     (clk),
        .wr_en   (wrEn),
        .wr_ptr  (wrPtr),
        .wr_data (cSt_data),
        .rd_ptr  (rdPtr),
        .rd_data (rdData)
    );

    assign cSt_rdy   = rdyReg;
    assign occupancy = occReg;
    assign out_vld   = (occReg != '0);
    // Masked so the idle output reads as zero instead of stale storage.
    assign out_data  = out_vld ? rdData : '0;

`ifdef C_ST_RX_STATS_EN
    logic [CNT_W:0] sumWide;

    assign sumWide = {1'b0, rx_sum} + (CNT_W+1)'(cSt_data);

    // Flush does not clear the statistics; only rst does.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count <= '0;
            rx_sum   <= '0;
        end else if (pushEn && !flush) begin
            rx_count <= rx_count + CNT_W'(1);
            rx_sum   <= sumWide[CNT_W] ? '1 : sumWide[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_c_st_rx_buffer.sv
// Scoreboard bench for c_st_rx_buffer: directed scenarios followed by random traffic.
// Latency: model expects each accepted beat visible the cycle after its push.
// Backpressure: driver holds beats until cSt_rdy, model predicts cSt_rdy independently.
module tb_c_st_rx_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cSt_vld;
    logic [9:0]       cSt_data;
    logic             cSt_rdy;
    logic             out_vld;
    logic [9:0]       out_data;
    logic             out_rdy;
    logic             flush;
    logic [OCC_W-1:0] occupancy;
`ifdef C_ST_RX_STATS_EN
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] rx_sum;
`endif

    always #5 clk = ~clk;

    c_st_rx_buffer #(
        .DEPTH (DEPTH)
`ifdef C_ST_RX_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cSt_vld   (cSt_vld),
        .cSt_data  (cSt_data),
        .cSt_rdy   (cSt_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef C_ST_RX_STATS_EN
        ,
        .rx_count  (rx_count),
        .rx_sum    (rx_sum)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Reference model: a queue of beats the buffer must hold, plus the
    // ready state implied by "not full and not flushing" after each edge.
    logic [9:0] expQ[$];
    bit         modelRdy = 1'b0;
`ifdef C_ST_RX_STATS_EN
    int unsigned mCnt = 0;
    int unsigned mSum = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge: reset and flush empty the buffer, otherwise
    // an accepted beat joins the tail (pops were retired by the monitor).
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            modelRdy = 1'b0;
`ifdef C_ST_RX_STATS_EN
            mCnt = 0;
            mSum = 0;
`endif
        end else if (flush) begin
            expQ.delete();
            modelRdy = 1'b0;
        end else begin
            if (cSt_vld && modelRdy) begin
                expQ.push_back(cSt_data);
`ifdef C_ST_RX_STATS_EN
                mCnt = (mCnt + 1) % (1 << CNT_W);
                mSum = mSum + cSt_data;
                if (mSum > (1 << CNT_W) - 1) mSum = (1 << CNT_W) - 1;
`endif
            end
            modelRdy = (expQ.size() != DEPTH);
        end
    end

    // Monitor: compare observable state mid-cycle; on a handshake pop the
    // head of the expected queue and compare it with the presented beat.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("out_vld", int'(out_vld), int'(expQ.size() != 0));
            chk("occupancy", int'(occupancy), expQ.size());
            chk("cSt_rdy", int'(cSt_rdy), int'(modelRdy));
`ifdef C_ST_RX_STATS_EN
            chk("rx_count", int'(rx_count), int'(mCnt));
            chk("rx_sum", int'(rx_sum), int'(mSum));
`endif
            if (expQ.size() > 0 && out_rdy) begin
                chk("out_data", int'(out_data), int'(expQ.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a beat and hold it until the cycle in which cSt_rdy is high.
    task automatic send(input logic [9:0] d);
        int n = 0;
        cSt_vld  = 1'b1;
        cSt_data = d;
        while (!cSt_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accepted t=%0t", $time);
        end
        @(posedge clk);
        #1;
        cSt_vld = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        cSt_vld  = 1'b0;
        cSt_data = '0;
        out_rdy  = 1'b0;
        flush    = 1'b0;
        idle(3);
        checkEn = 1'b1;
        chk("reset_out_data", int'(out_data), 0);
        rst = 1'b0;

        // Basic ordered transfer with a consumer that is always ready.
        out_rdy = 1'b1;
        send(10'h005);
        send(10'h3FF);
        send(10'h123);
        idle(3);

        // Fill to full, single-cycle pop, then the fifth beat goes in.
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(10'(10'h040 + i));
        cSt_vld  = 1'b1;
        cSt_data = 10'h055;
        idle(1);
        out_rdy = 1'b1;
        idle(1);
        out_rdy = 1'b0;
        send(10'h055);
        out_rdy = 1'b1;
        idle(6);

        // Steady push+pop at occupancy 2 so both pointers wrap.
        out_rdy = 1'b0;
        send(10'h101);
        send(10'h102);
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cSt_vld  = 1'b1;
            cSt_data = 10'($urandom);
            idle(1);
        end
        cSt_vld = 1'b0;
        idle(4);

        // Flush with a coincident push at occupancy 3.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(10'(10'h200 + i));
        cSt_vld  = 1'b1;
        cSt_data = 10'h2AA;
        flush    = 1'b1;
        idle(1);
        cSt_vld = 1'b0;
        flush   = 1'b0;
        idle(3);
        out_rdy = 1'b1;
        idle(2);

        // Statistics saturation, then flush and reset behaviour.
        for (int i = 0; i < 70; i++) send(10'h3FF);
        idle(2);
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        // Reset mid-transfer with three beats held.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(10'(10'h300 + i));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cSt_vld  = 1'($urandom_range(0, 1));
            cSt_data = 10'($urandom);
            out_rdy  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            idle(1);
        end
        cSt_vld = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
        out_rdy = 1'b1;
        idle(6);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
